// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared mode encodings, run states and clog2 helper for demux_packer
package demux_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_SDR  = 2'd1,
        MODE_DDR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_packer_if.sv
// rtl/demux_packer_if.sv - control, sample and packed-word signals of demux_packer
// master: drives enable/mode/strobe/flush/indata/indata180, observes outdata/outvalid/outcount
// slave : the packer itself
interface demux_packer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
);
    import demux_pkg::*;

    localparam int RATIO     = OUT_WIDTH / IN_WIDTH;
    localparam int CNT_WIDTH = clog2(RATIO) + 1;

    logic                 enable;
    logic [1:0]           mode;
    logic                 strobe;
    logic                 flush;
    logic [IN_WIDTH-1:0]  indata;
    logic [IN_WIDTH-1:0]  indata180;
    logic [OUT_WIDTH-1:0] outdata;
    logic                 outvalid;
    logic [CNT_WIDTH-1:0] outcount;

    modport master (
        output enable, mode, strobe, flush, indata, indata180,
        input  outdata, outvalid, outcount
    );

    modport slave (
        input  enable, mode, strobe, flush, indata, indata180,
        output outdata, outvalid, outcount
    );

endinterface

// File: rtl/demux_slice_shifter.sv
// rtl/demux_slice_shifter.sv - IN_WIDTH-slice insert register with fill counter
// clock/reset : sample clock, synchronous active-high reset
// clear       : drop any partial word (not running)
// load_num    : samples offered this cycle (0, 1 or 2)
// data_lo     : earlier sample, goes to slice fill
// data_hi     : later sample, goes to slice fill+1 (only when load_num == 2)
// flush       : emit a partial word if anything is held
// emit        : a word is ready this cycle (combinational)
// emit_data   : word including this cycle's samples, unused upper slices zero
// emit_count  : number of valid slices in emit_data
module demux_slice_shifter
    import demux_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int RATIO    = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [1:0]                   load_num,
    input  logic [IN_WIDTH-1:0]          data_lo,
    input  logic [IN_WIDTH-1:0]          data_hi,
    input  logic                         flush,
    output logic                         emit,
    output logic [IN_WIDTH*RATIO-1:0]    emit_data,
    output logic [clog2(RATIO):0]        emit_count
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_WIDTH = clog2(RATIO) + 1;

    logic [OUT_WIDTH-1:0] word_q;
    logic [OUT_WIDTH-1:0] word_new;
    logic [CNT_WIDTH-1:0] fill_q;
    logic [CNT_WIDTH-1:0] fill_new;
    logic [CNT_WIDTH-1:0] fill_p1;

    // Samples are written at their slice index rather than shifted, so a
    // partial word already sits in the low slices with zeros above it.
    always_comb begin
        fill_new = fill_q + CNT_WIDTH'(load_num);
        fill_p1  = fill_q + CNT_WIDTH'(1);
        word_new = word_q;
        for (int i = 0; i < RATIO; i++) begin
            if (load_num != 2'd0 && CNT_WIDTH'(i) == fill_q)
                word_new[i*IN_WIDTH +: IN_WIDTH] = data_lo;
            if (load_num == 2'd2 && CNT_WIDTH'(i) == fill_p1)
                word_new[i*IN_WIDTH +: IN_WIDTH] = data_hi;
        end
        // A completing sample wins over flush, giving a full-count word.
        emit       = (fill_new == CNT_WIDTH'(RATIO)) ||
                     (flush && fill_new != '0);
        emit_data  = word_new;
        emit_count = fill_new;
    end

    always_ff @(posedge clock) begin
        if (reset || clear || emit) begin
            word_q <= '0;
            fill_q <= '0;
        end else begin
            word_q <= word_new;
            fill_q <= fill_new;
        end
    end

endmodule

// File: rtl/demux_packer.sv
// rtl/demux_packer.sv - packs rising/falling-edge capture samples into wide words
// clock  : sample clock, all logic on its rising edge
// reset  : synchronous active-high reset
// bus    : demux_packer_if.slave - enable/mode/strobe/flush/indata/indata180 in,
//          outdata/outvalid/outcount out (registered)
module demux_packer
    import demux_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    demux_packer_if.slave  bus
);

    localparam int RATIO     = OUT_WIDTH / IN_WIDTH;
    localparam int CNT_WIDTH = clog2(RATIO) + 1;

    run_state_e           state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [IN_WIDTH-1:0]  delay_q;

    logic                 run_active;
    logic                 pass_emit;
    logic                 sh_clear;
    logic                 sh_flush;
    logic [1:0]           load_num;
    logic [IN_WIDTH-1:0]  data_lo;
    logic                 sh_emit;
    logic [OUT_WIDTH-1:0] sh_data;
    logic [CNT_WIDTH-1:0] sh_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_PASS;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            // Falling-edge sample is delayed one cycle so it precedes the
            // next rising-edge sample in time order.
            delay_q <= bus.indata180;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        run_active = 1'b0;
        pass_emit  = 1'b0;
        load_num   = 2'd0;
        data_lo    = bus.indata;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_RUN;
                    mode_d  = (mode_e'(bus.mode) == MODE_RSVD) ? MODE_PASS
                                                               : mode_e'(bus.mode);
                end
            end
            ST_RUN: begin
                if (!bus.enable)
                    state_d = ST_IDLE;
                else
                    run_active = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (run_active) begin
            case (mode_q)
                MODE_SDR: load_num = bus.strobe ? 2'd1 : 2'd0;
                MODE_DDR: begin
                    load_num = 2'd2;
                    data_lo  = delay_q;
                end
                default:  pass_emit = bus.strobe;
            endcase
        end

        // Leaving RUN discards the partial word; flush in that same cycle
        // still emits it because emit is evaluated before the clear lands.
        sh_clear = !run_active;
        sh_flush = bus.flush && (state_q == ST_RUN);
    end

    demux_slice_shifter #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO)
    ) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .clear      (sh_clear),
        .load_num   (load_num),
        .data_lo    (data_lo),
        .data_hi    (bus.indata),
        .flush      (sh_flush),
        .emit       (sh_emit),
        .emit_data  (sh_data),
        .emit_count (sh_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.outdata  <= '0;
            bus.outvalid <= 1'b0;
            bus.outcount <= '0;
        end else begin
            bus.outvalid <= 1'b0;
            if (pass_emit) begin
                bus.outdata  <= OUT_WIDTH'(bus.indata);
                bus.outcount <= CNT_WIDTH'(1);
                bus.outvalid <= 1'b1;
            end else if (sh_emit) begin
                bus.outdata  <= sh_data;
                bus.outcount <= sh_count;
                bus.outvalid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/demux_packer.md
Name: demux_packer

Overview:
- Parametrised successor to the sampler-front-end demultiplexer in the logic-analyzer capture path.
- Captures IN_WIDTH channels on the rising edge (indata) and on the falling edge (indata180, already registered on the inverted clock upstream).
- Packs successive samples into OUT_WIDTH words with a valid strobe.
- Sits between the input synchroniser and the trigger/sample-buffer path; supports pass-through, single-rate packing and double-rate (demux) packing selected at run start.

Parameters:
- IN_WIDTH, 16, channels per sample.
- OUT_WIDTH, 32, output word width; must be an integer multiple of IN_WIDTH.
- RATIO, OUT_WIDTH/IN_WIDTH, samples per output word (derived localparam, not overridden); must be >=2 and even for DDR mode.

Ports:
- clock  in  1  sample clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run; mode is latched on its rising edge.
- mode  in  2  0=PASS, 1=SDR pack, 2=DDR pack, 3=reserved (treated as PASS).
- strobe  in  1  sample qualifier from the rate divider; ignored in DDR mode.
- flush  in  1  single-cycle pulse: emit the partial word.
- indata  in  IN_WIDTH  rising-edge sample.
- indata180  in  IN_WIDTH  falling-edge sample.
- outdata  out  OUT_WIDTH  packed word, registered.
- outvalid  out  1  one-cycle strobe qualifying outdata.
- outcount  out  clog2(RATIO)+1  number of valid samples in outdata (RATIO except on flush).

Behaviour:
- Reset:
  - outdata=0, outvalid=0, outcount=0.
  - Fill count=0, shift register=0, falling-edge delay register=0, latched mode=PASS, run state=IDLE.
- States:
  - IDLE: enable low; no output; fill count held 0. On enable rising edge, latch mode and go to RUN.
  - RUN: on enable low, go to IDLE.
- mode changes while in RUN are ignored.
- Falling-edge delay register: loads indata180 every clock in every state. This delays the falling sample so it precedes the next rising sample in time order.
- PASS:
  - Each cycle with strobe=1: outdata={zeros,indata}, outcount=1, outvalid=1 on the next cycle.
  - Latency 1.
- SDR:
  - Each strobe=1 cycle shifts indata into the word; oldest sample ends in the LSB slice.
  - When fill reaches RATIO: outdata=word, outcount=RATIO, outvalid=1 the following cycle, and fill restarts at 0.
  - A sample captured in the same cycle as completion belongs to the next word; there are no gaps.
- DDR:
  - Every cycle in RUN contributes two samples, in order: delayed indata180 (earlier), then indata (later). The pair occupies adjacent slices, with the earlier sample in the lower slice.
  - A word completes every RATIO/2 cycles.
  - For RATIO=2, outdata={indata, delayed indata180} every cycle.
  - The first pair after entering RUN uses the delay-register value from the preceding cycle.
- flush:
  - In RUN with fill>0: the next cycle emits the partial word, unused upper slices are zero, outcount=fill, and fill resets.
  - flush with fill=0: no output.
  - flush coincident with a sample:
    - If that sample completes the word (SDR, or DDR with both samples fitting), emit the full word with outcount=RATIO.
    - Otherwise include the sample in the partial word.
  - A DDR pair that would overflow cannot occur because RATIO is even.
- enable falling edge: a partial word is discarded with no outvalid, unless flush is asserted in the same cycle, in which case the partial word is emitted.
- reset mid-run: takes effect at the next edge and overrides flush and enable; the partial word is lost.
- outvalid is never asserted for two words in one cycle; throughput is at most one word per cycle.

Decomposition:
- Shared package (demux_pkg): mode encodings MODE_PASS/MODE_SDR/MODE_DDR and the clog2 function.
- One natural sub-module: demux_slice_shifter, the parametrised IN_WIDTH-slice shift/insert register with fill counter. The top level holds the run FSM, the delay register and the output register.

Test Plan:
- Reset: assert reset with enable=1 and flush=1 → outdata=0, outvalid=0, outcount=0 for every cycle while reset is high.
- SDR, RATIO=2, strobe every cycle, indata=0x0001,0x0002,0x0003,0x0004 → outvalid on cycles 2 and 4 with outdata=0x00020001, then 0x00040003, outcount=2.
- DDR, RATIO=2: indata180=0xA000+n, indata=0xB000+n at cycle n → each cycle outdata={0xB000+n, 0xA000+n-1}, outvalid continuous.
- SDR with OUT_WIDTH=64 (RATIO=4): three strobes (0x11,0x22,0x33), then flush → outdata=0x0000_0033_0022_0011, outcount=3; a flush on the following cycle produces no output.
- Mode change mid-RUN from SDR to DDR → packing stays SDR until enable drops and re-rises; enable drop with fill=1 → no outvalid.
- PASS with strobe on alternate cycles, indata=0x1234 → outvalid on alternate cycles, outdata=0x00001234, outcount=1.
